// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the multi-cycle serial subtractor.
// The FSM encoding is fixed so legacy code can match on the raw 2-bit values.
package serial_subtractor_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // One spare bit so the counter can hold N itself without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (bi & ~(x ^ y));

endmodule

// File: rtl/serial_subtractor.sv
// Serial subtractor: diff = a - b - bin, BITS_PER_CYCLE bits per clock.
// Define SERSUB_OVERFLOW_EN to add the two's-complement overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int BPC_SAFE = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
    localparam int N        = WIDTH / BPC_SAFE;
    localparam int CW       = cnt_width(N);

    generate
        if (BITS_PER_CYCLE < 1) begin : g_bpc_err
            $error("serial_subtractor: BITS_PER_CYCLE must be >= 1");
        end else if (WIDTH < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_width_err
            $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    state_t                    state;
    logic [WIDTH-1:0]          ad_sr;
    logic [WIDTH-1:0]          b_sr;
    logic                      borrow;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] chunk_x;
    logic [BITS_PER_CYCLE-1:0] chunk_y;
    logic [BITS_PER_CYCLE-1:0] chunk_d;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [WIDTH-1:0]          diff_nxt;
    logic                      accept;
    logic                      last;

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign accept  = start && (state != RUN);
    assign last    = (cnt == CW'(N - 1));

    assign chunk_x  = ad_sr[BITS_PER_CYCLE-1:0];
    assign chunk_y  = b_sr[BITS_PER_CYCLE-1:0];
    assign chain[0] = borrow;

    generate
        for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
            fs_cell u_cell (
                .x  (chunk_x[i]),
                .y  (chunk_y[i]),
                .bi (chain[i]),
                .d  (chunk_d[i]),
                .bo (chain[i+1])
            );
        end
    endgenerate

    // Minuend bits leave at the LSB while difference bits enter at the MSB,
    // so one register serves as both the a operand and the partial result.
    generate
        if (N == 1) begin : g_single
            assign diff_nxt = chunk_d;
        end else begin : g_multi
            assign diff_nxt = {chunk_d, ad_sr[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ad_sr  <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                RUN: begin
                    ad_sr  <= diff_nxt;
                    b_sr   <= b_sr >> BITS_PER_CYCLE;
                    borrow <= chain[BITS_PER_CYCLE];
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        ad_sr  <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (busy && last) begin
            diff <= diff_nxt;
            bout <= chain[BITS_PER_CYCLE];
        end
    end

`ifdef SERSUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (busy && last) begin
                ovf <= (a_msb ^ b_msb) & (a_msb ^ diff_nxt[WIDTH-1]);
            end
        end
    end
`endif

endmodule
